json_tokenizer: RTL and testbench

Streaming hardware JSON lexer, the RTL counterpart of the package's software decoder. It consumes one byte per cycle over a valid/ready stream and emits typed token events with byte position and length. It tracks object/array nesting on an internal bracket stack and reports syntax errors using the same error taxonomy as the package's error objects. It sits between a byte source (DMA/UART/AXI-S adapter) and downstream value builders.

---
 rtl/json_tokenizer.sv | 318 +++++++++++++++++++++++++++++++
 tb/tb_json_tokenizer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/json_tokenizer.sv
// Streaming JSON lexer: one byte per cycle in, typed token events out via a small FWFT FIFO.
// Define JSON_TOKENIZER_POS_EN to enable byte position/length reporting (tok_pos, tok_len, err_pos).
module json_tokenizer #(
  parameter int unsigned MAX_DEPTH      = 16,
  parameter int unsigned POS_W          = 32,
  parameter int unsigned TOK_FIFO_DEPTH = 4,
  localparam int unsigned DepthW        = $clog2(MAX_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_data,
  input  logic              in_last,
  output logic              tok_valid,
  input  logic              tok_ready,
  output logic [3:0]        tok_kind,
  output logic [POS_W-1:0]  tok_pos,
  output logic [POS_W-1:0]  tok_len,
  output logic              err_valid,
  output logic [2:0]        err_kind,
  output logic [POS_W-1:0]  err_pos,
  output logic [DepthW-1:0] depth
);

  localparam int unsigned CntW = $clog2(TOK_FIFO_DEPTH + 1);
  localparam int unsigned PtrW = $clog2(TOK_FIFO_DEPTH);
  localparam logic [MAX_DEPTH-1:0] StackOne = MAX_DEPTH'(1);

  localparam logic [3:0] TkObjBegin = 4'd1, TkObjEnd = 4'd2, TkArrBegin = 4'd3, TkArrEnd = 4'd4;
  localparam logic [3:0] TkString = 4'd5, TkNumber = 4'd6, TkTrue = 4'd7;
  localparam logic [3:0] TkColon = 4'd10, TkComma = 4'd11, TkEoi = 4'd12;
  localparam logic [2:0] ErrUnexpected = 3'd1, ErrBadLiteral = 3'd2, ErrDepth = 3'd3;
  localparam logic [2:0] ErrMismatch = 3'd4, ErrUnterminated = 3'd5, ErrUnbalanced = 3'd6;

  typedef enum logic [2:0] {
    StIdle, StString, StStrEsc, StNumber, StLiteral, StError
  } state_e;

  state_e               state_q, state_d;
  logic [MAX_DEPTH-1:0] stack_q, stack_d;
  logic [DepthW-1:0]    depth_q, depth_d;
  logic [1:0]           lit_sel_q, lit_sel_d;
  logic [2:0]           lit_idx_q, lit_idx_d;
  logic [POS_W-1:0]     pos_q, start_q, pos_nx, num_start;

  logic             in_fire, do_idle, br_arr, top_arr, is_num;
  logic             err_fire;
  logic [2:0]       err_code;
  logic [POS_W-1:0] err_at;

  // Candidate tokens for this byte, in emission order: closing, structural, final number, EOI
  logic             s_v    [4];
  logic [3:0]       s_kind [4];
  logic [POS_W-1:0] s_pos  [4];
  logic [POS_W-1:0] s_len  [4];

  logic [1:0]       w_n;
  logic [3:0]       w_kind [3];
  logic [POS_W-1:0] w_pos  [3];
  logic [POS_W-1:0] w_len  [3];

  logic [3:0]       kind_mem [TOK_FIFO_DEPTH];
  logic [POS_W-1:0] pos_mem  [TOK_FIFO_DEPTH];
  logic [POS_W-1:0] len_mem  [TOK_FIFO_DEPTH];
  logic [PtrW-1:0]  rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             pop;

  logic             err_valid_q;
  logic [2:0]       err_kind_q;
  logic [POS_W-1:0] err_pos_q;

`ifdef JSON_TOKENIZER_POS_EN
  localparam bit PosEn = 1'b1;

  // A token starts when entering a multi-byte state from outside it (escape return excluded)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos_q   <= '0;
      start_q <= '0;
    end else if (in_fire) begin
      pos_q <= in_last ? '0 : pos_q + POS_W'(1);
      if ((state_d inside {StString, StNumber, StLiteral}) && (state_d != state_q) &&
          (state_q != StStrEsc)) begin
        start_q <= pos_q;
      end
    end
  end
`else
  localparam bit PosEn = 1'b0;

  assign pos_q   = '0;
  assign start_q = '0;
`endif

  function automatic logic [7:0] lit_char(input logic [1:0] sel, input logic [2:0] idx);
    logic [39:0] word;
    case (sel)
      2'd0:    word = {"true", 8'h00};
      2'd1:    word = "false";
      2'd2:    word = {"null", 8'h00};
      default: word = '0;
    endcase
    word = word << (8 * idx);
    return word[39:32];
  endfunction

  function automatic logic [PtrW-1:0] ptr_add(input logic [PtrW-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= int'(TOK_FIFO_DEPTH)) s = s - int'(TOK_FIFO_DEPTH);
    return PtrW'(s);
  endfunction

  assign in_ready  = !rst && ((state_q == StError) || (count_q <= CntW'(TOK_FIFO_DEPTH - 3)));
  assign in_fire   = in_valid && in_ready;
  assign pos_nx    = pos_q + POS_W'(1);
  assign num_start = (state_q == StNumber) ? start_q : pos_q;
  assign br_arr    = ~in_data[5];
  assign top_arr   = |(stack_q & (StackOne << (depth_q - DepthW'(1))));
  assign is_num    = (in_data >= 8'h30 && in_data <= 8'h39) || in_data == 8'h2b ||
                     in_data == 8'h2d || in_data == 8'h2e || in_data == 8'h65 || in_data == 8'h45;

  always_comb begin
    state_d   = state_q;
    stack_d   = stack_q;
    depth_d   = depth_q;
    lit_sel_d = lit_sel_q;
    lit_idx_d = lit_idx_q;
    err_fire  = 1'b0;
    err_code  = '0;
    err_at    = pos_q;
    do_idle   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s_v[i]    = 1'b0;
      s_kind[i] = '0;
      s_pos[i]  = pos_q;
      s_len[i]  = POS_W'(1);
    end

    if (in_fire) begin
      unique case (state_q)
        StIdle: do_idle = 1'b1;
        StString: begin
          if (in_data == 8'h22) begin
            s_v[0] = 1'b1; s_kind[0] = TkString;
            s_pos[0] = start_q; s_len[0] = pos_nx - start_q;
            state_d = StIdle;
          end else if (in_data == 8'h5c) begin
            state_d = StStrEsc;
          end else if (in_data < 8'h20) begin
            err_fire = 1'b1; err_code = ErrUnexpected;
          end
        end
        StStrEsc: state_d = StString;
        StNumber: begin
          if (!is_num) begin
            s_v[0] = 1'b1; s_kind[0] = TkNumber;
            s_pos[0] = start_q; s_len[0] = pos_q - start_q;
            state_d = StIdle;
            do_idle = 1'b1;
          end
        end
        StLiteral: begin
          if (in_data != lit_char(lit_sel_q, lit_idx_q)) begin
            err_fire = 1'b1; err_code = ErrBadLiteral;
          end else if (lit_idx_q == ((lit_sel_q == 2'd1) ? 3'd4 : 3'd3)) begin
            s_v[0] = 1'b1; s_kind[0] = TkTrue + {2'b00, lit_sel_q};
            s_pos[0] = start_q; s_len[0] = pos_nx - start_q;
            state_d = StIdle;
          end else begin
            lit_idx_d = lit_idx_q + 3'd1;
          end
        end
        StError: ;
        default: ;
      endcase

      if (do_idle) begin
        case (in_data)
          8'h20, 8'h09, 8'h0d, 8'h0a: ;
          8'h7b, 8'h5b: begin
            if (depth_q == DepthW'(MAX_DEPTH)) begin
              err_fire = 1'b1; err_code = ErrDepth;
            end else begin
              stack_d = (stack_q & ~(StackOne << depth_q)) | (br_arr ? (StackOne << depth_q) : '0);
              depth_d = depth_q + DepthW'(1);
              s_v[1] = 1'b1; s_kind[1] = br_arr ? TkArrBegin : TkObjBegin;
            end
          end
          8'h7d, 8'h5d: begin
            if (depth_q == '0 || top_arr != br_arr) begin
              err_fire = 1'b1; err_code = ErrMismatch;
            end else begin
              depth_d = depth_q - DepthW'(1);
              s_v[1] = 1'b1; s_kind[1] = br_arr ? TkArrEnd : TkObjEnd;
            end
          end
          8'h3a: begin s_v[1] = 1'b1; s_kind[1] = TkColon; end
          8'h2c: begin s_v[1] = 1'b1; s_kind[1] = TkComma; end
          8'h22: state_d = StString;
          8'h74: begin state_d = StLiteral; lit_sel_d = 2'd0; lit_idx_d = 3'd1; end
          8'h66: begin state_d = StLiteral; lit_sel_d = 2'd1; lit_idx_d = 3'd1; end
          8'h6e: begin state_d = StLiteral; lit_sel_d = 2'd2; lit_idx_d = 3'd1; end
          default: begin
            if (in_data == 8'h2d || (in_data >= 8'h30 && in_data <= 8'h39)) begin
              state_d = StNumber;
            end else begin
              err_fire = 1'b1; err_code = ErrUnexpected;
            end
          end
        endcase
      end

      if (err_fire) state_d = StError;

      if (in_last) begin
        if (state_q != StError && !err_fire) begin
          if (state_d inside {StString, StStrEsc, StLiteral}) begin
            err_fire = 1'b1; err_code = ErrUnterminated; err_at = pos_nx;
          end else begin
            if (state_d == StNumber) begin
              s_v[2] = 1'b1; s_kind[2] = TkNumber;
              s_pos[2] = num_start; s_len[2] = pos_nx - num_start;
            end
            if (depth_d != '0) begin
              err_fire = 1'b1; err_code = ErrUnbalanced; err_at = pos_nx;
            end else begin
              s_v[3] = 1'b1; s_kind[3] = TkEoi; s_pos[3] = pos_nx; s_len[3] = '0;
            end
          end
        end
        state_d = StIdle;
        stack_d = '0;
        depth_d = '0;
      end
    end
  end

  // Pack the valid candidates densely for the FIFO write port
  always_comb begin
    w_n = '0;
    for (int i = 0; i < 3; i++) begin
      w_kind[i] = '0;
      w_pos[i]  = '0;
      w_len[i]  = '0;
    end
    for (int i = 0; i < 4; i++) begin
      if (s_v[i] && w_n < 2'd3) begin
        w_kind[w_n] = s_kind[i];
        w_pos[w_n]  = PosEn ? s_pos[i] : '0;
        w_len[w_n]  = PosEn ? s_len[i] : '0;
        w_n         = w_n + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      stack_q     <= '0;
      depth_q     <= '0;
      lit_sel_q   <= '0;
      lit_idx_q   <= '0;
      err_valid_q <= 1'b0;
      err_kind_q  <= '0;
      err_pos_q   <= '0;
    end else begin
      state_q     <= state_d;
      stack_q     <= stack_d;
      depth_q     <= depth_d;
      lit_sel_q   <= lit_sel_d;
      lit_idx_q   <= lit_idx_d;
      err_valid_q <= err_fire;
      if (err_fire) begin
        err_kind_q <= err_code;
        err_pos_q  <= PosEn ? err_at : '0;
      end
    end
  end

  assign pop = tok_valid && tok_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(TOK_FIFO_DEPTH); i++) begin
        kind_mem[i] <= '0;
        pos_mem[i]  <= '0;
        len_mem[i]  <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (2'(i) < w_n) begin
          kind_mem[ptr_add(wr_ptr_q, i)] <= w_kind[i];
          pos_mem[ptr_add(wr_ptr_q, i)]  <= w_pos[i];
          len_mem[ptr_add(wr_ptr_q, i)]  <= w_len[i];
        end
      end
      wr_ptr_q <= ptr_add(wr_ptr_q, int'(w_n));
      if (pop) rd_ptr_q <= ptr_add(rd_ptr_q, 1);
      count_q <= count_q + CntW'(w_n) - CntW'(pop);
    end
  end

  assign tok_valid = (count_q != '0);
  assign tok_kind  = kind_mem[rd_ptr_q];
  assign tok_pos   = pos_mem[rd_ptr_q];
  assign tok_len   = len_mem[rd_ptr_q];
  assign err_valid = err_valid_q;
  assign err_kind  = err_kind_q;
  assign err_pos   = err_pos_q;
  assign depth     = depth_q;

endmodule

// File: tb/tb_json_tokenizer.sv
// Scoreboard bench for json_tokenizer: expected tokens/errors queued by stimulus, popped by monitor.
module tb_json_tokenizer;

`ifdef JSON_TOKENIZER_POS_EN
  localparam bit PosEn = 1'b1;
`else
  localparam bit PosEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = '0;
  logic        in_last = 1'b0;
  logic        tok_valid;
  logic        tok_ready = 1'b1;
  logic [3:0]  tok_kind;
  logic [31:0] tok_pos;
  logic [31:0] tok_len;
  logic        err_valid;
  logic [2:0]  err_kind;
  logic [31:0] err_pos;
  logic [1:0]  depth;

  always #5 clk = ~clk;

  json_tokenizer #(.MAX_DEPTH(2), .POS_W(32), .TOK_FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .tok_valid(tok_valid), .tok_ready(tok_ready), .tok_kind(tok_kind),
    .tok_pos(tok_pos), .tok_len(tok_len), .err_valid(err_valid), .err_kind(err_kind),
    .err_pos(err_pos), .depth(depth)
  );

  typedef struct {
    logic [3:0]  kind;
    logic [31:0] pos;
    logic [31:0] len;
  } tok_t;
  typedef struct {
    logic [2:0]  kind;
    logic [31:0] pos;
  } err_t;

  tok_t exp_tok[$];
  err_t exp_err[$];
  int   total = 0;
  int   bad = 0;
  int   ready_mode = 0;
  bit   saw_stall = 1'b0;

  function automatic logic [31:0] ep(input int v);
    return PosEn ? 32'(v) : 32'd0;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic etok(input int kind, input int pos, input int len);
    tok_t t;
    t.kind = 4'(kind);
    t.pos  = ep(pos);
    t.len  = ep(len);
    exp_tok.push_back(t);
  endtask

  task automatic eerr(input int kind, input int pos);
    err_t e;
    e.kind = 3'(kind);
    e.pos  = ep(pos);
    exp_err.push_back(e);
  endtask

  task automatic send(input logic [7:0] b, input bit last);
    int n;
    in_valid = 1'b1;
    in_data  = b;
    in_last  = last;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      n++;
      saw_stall = 1'b1;
      @(negedge clk);
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL in_ready_timeout: got 0 want 1");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_str(input string s, input bit last);
    for (int i = 0; i < s.len(); i++) send(s[i], last && (i == s.len() - 1));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_tok.size() != 0 || exp_err.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("drain_tok", 64'(exp_tok.size()), 64'd0);
    check("drain_err", 64'(exp_err.size()), 64'd0);
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    int k;
    k = 0;
    forever begin
      @(posedge clk);
      #1;
      k++;
      case (ready_mode)
        0:       tok_ready = 1'b1;
        1:       tok_ready = (k % 4 == 0);
        default: tok_ready = 1'b0;
      endcase
    end
  end

  // Monitor: every handshaken token and every error pulse is matched against the queues
  initial begin
    forever begin
      tok_t et;
      err_t ee;
      @(negedge clk);
      if (!rst && tok_valid && tok_ready) begin
        if (exp_tok.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_token: got kind %0d pos %0d, want none", tok_kind, tok_pos);
        end else begin
          et = exp_tok.pop_front();
          check("tok_kind", 64'(tok_kind), 64'(et.kind));
          check("tok_pos", 64'(tok_pos), 64'(et.pos));
          check("tok_len", 64'(tok_len), 64'(et.len));
        end
      end
      if (!rst && err_valid) begin
        if (exp_err.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_error: got kind %0d pos %0d, want none", err_kind, err_pos);
        end else begin
          ee = exp_err.pop_front();
          check("err_kind", 64'(err_kind), 64'(ee.kind));
          check("err_pos", 64'(err_pos), 64'(ee.pos));
        end
      end
    end
  end

  task automatic expect_doc1();
    etok(1, 0, 1);  etok(5, 1, 3);  etok(10, 4, 1); etok(3, 5, 1);  etok(6, 6, 1);
    etok(11, 7, 1); etok(7, 8, 4);  etok(4, 12, 1); etok(2, 13, 1); etok(12, 14, 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_tok_valid", 64'(tok_valid), 64'd0);
    check("rst_err_valid", 64'(err_valid), 64'd0);
    check("rst_depth", 64'(depth), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;

    expect_doc1();
    send_str("{\"a\":[1,true]}", 1'b1);
    drain();
    check("doc1_depth", 64'(depth), 64'd0);

    ready_mode = 1;
    saw_stall  = 1'b0;
    expect_doc1();
    send_str("{\"a\":[1,true]}", 1'b1);
    drain();
    check("backpressure_stall", 64'(saw_stall), 64'd1);
    ready_mode = 0;

    etok(5, 0, 6); etok(12, 6, 0);
    send_str("\"a\\\"b\"", 1'b1);
    drain();

    etok(3, 0, 1); eerr(4, 1);
    send_str("[}", 1'b0);
    send_str("xyz", 1'b1);
    etok(9, 0, 4); etok(12, 4, 0);
    send_str("null", 1'b1);
    drain();

    etok(3, 0, 1); etok(3, 1, 1); eerr(3, 2);
    send_str("[[", 1'b0);
    check("depth_two", 64'(depth), 64'd2);
    send_str("[", 1'b1);
    eerr(2, 1);
    send_str("tx", 1'b1);
    drain();
    check("depth_after_err", 64'(depth), 64'd0);

    etok(3, 0, 1); etok(6, 1, 2); eerr(6, 3);
    send_str("[12", 1'b1);
    drain();

    etok(3, 0, 1); etok(6, 1, 1); etok(4, 2, 1); etok(12, 3, 0);
    send_str("[5]", 1'b1);
    drain();

    eerr(1, 0);
    send_str("@", 1'b1);
    eerr(1, 2);
    send_str("\"a", 1'b0);
    send(8'h01, 1'b1);
    eerr(5, 4);
    send_str("fals", 1'b1);
    drain();

    ready_mode = 2;
    send_str("[", 1'b0);
    @(negedge clk);
    check("held_tok_valid", 64'(tok_valid), 64'd1);
    check("held_depth", 64'(depth), 64'd1);
    @(posedge clk);
    #1;
    send_str("\"ab", 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_in_ready", 64'(in_ready), 64'd0);
    check("midrst_tok_valid", 64'(tok_valid), 64'd0);
    check("midrst_depth", 64'(depth), 64'd0);
    check("midrst_tok_kind", 64'(tok_kind), 64'd0);
    check("midrst_err_kind", 64'(err_kind), 64'd0);
    check("midrst_err_pos", 64'(err_pos), 64'd0);
    ready_mode = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_release_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    etok(6, 0, 1); etok(12, 1, 0);
    send_str("5", 1'b1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
